// File: rtl/deparser.sv
// deparser: rebuilds an egress header buffer from a latched source buffer.
// Headers are emitted in ascending id order (one per cycle), headers whose
// emit bit is clear are dropped, and the payload (everything after the
// furthest parsed header end) is appended in a final TAIL cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           job request (FREE only; mod_start_i wins)
//   pkt_hdr_i         source bytes, byte i at index i
//   parsed_hdrs_i     per-header source offset, NO_HEADER = absent
//   emit_mask_i       bit i set: emit header i if present
//   busy_o            high in EMIT/TAIL
//   ready_o           result valid, held until next accepted start
//   pkt_hdr_o         rebuilt bytes; bytes past pkt_len_o are zero
//   pkt_len_o         valid byte count of pkt_hdr_o
//   overflow_o        some write landed at or beyond HDR_MAX_LEN
//   mod_start_i       header-length config strobe (FREE only)
//   mod_hdr_id_i      header id to configure (out-of-range ignored)
//   mod_hdr_len_i     header length in bytes

// One output byte lane. Each copy step (a header in EMIT or the payload in
// TAIL) is a window of cnt bytes written at wr_ptr and read from base; a lane
// decides on its own whether it falls inside the window and what it reads.
module deparser_byte #(
  parameter int HDR_MAX_LEN = 64,
  parameter int POS         = 0
) (
  input  logic [HDR_MAX_LEN-1:0][7:0] src,
  input  logic [31:0]                 wr_ptr,
  input  logic [31:0]                 base,
  input  logic [31:0]                 cnt,
  input  logic                        en,
  output logic                        hit,
  output logic [7:0]                  data
);
  localparam int          AW  = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
  localparam logic [31:0] MAX = 32'(HDR_MAX_LEN);
  localparam logic [31:0] P   = 32'(POS);

  logic [31:0] rel, sidx;

  assign rel  = P - wr_ptr;
  assign sidx = base + rel;
  assign hit  = en && (P >= wr_ptr) && (rel < cnt);
  // reads past the source buffer return zero
  assign data = (sidx < MAX) ? src[sidx[AW-1:0]] : 8'h00;
endmodule

module deparser #(
  parameter int          NUM_HEADERS = 2,
  parameter int          HDR_MAX_LEN = 64,
  parameter logic [31:0] NO_HEADER   = 32'hFFFF_FFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_i,
  input  logic [NUM_HEADERS-1:0][31:0] parsed_hdrs_i,
  input  logic [NUM_HEADERS-1:0]       emit_mask_i,
  output logic                         busy_o,
  output logic                         ready_o,
  output logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_o,
  output logic [31:0]                  pkt_len_o,
  output logic                         overflow_o,
  input  logic                         mod_start_i,
  input  logic [31:0]                  mod_hdr_id_i,
  input  logic [31:0]                  mod_hdr_len_i
);
  localparam int          IW  = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
  localparam logic [31:0] MAX = 32'(HDR_MAX_LEN);
  localparam logic [31:0] NH  = 32'(NUM_HEADERS);

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]                   state;
  logic [IW-1:0]                idx;
  logic [31:0]                  wr_ptr, payload_start;
  logic [HDR_MAX_LEN-1:0][7:0]  src_q;
  logic [NUM_HEADERS-1:0][31:0] offs_q;
  logic [NUM_HEADERS-1:0]       mask_q;
  logic [NUM_HEADERS-1:0][31:0] hdr_lens;

  logic [31:0] cur_off, cur_len, hdr_end;
  logic        present;
  logic        cp_en, cp_ovf;
  logic [31:0] cp_base, cp_cnt, cp_end;
  logic [31:0] tail_len, len_nxt;

  logic [HDR_MAX_LEN-1:0][7:0] lane_data;
  logic [HDR_MAX_LEN-1:0]      lane_hit;

  assign busy_o  = (state != FREE);
  assign cur_off = offs_q[idx];
  assign cur_len = hdr_lens[idx];
  assign present = (cur_off != NO_HEADER);
  assign hdr_end = cur_off + cur_len;

  // Shared copy window: current header in EMIT, payload in TAIL.
  always_comb begin
    cp_en   = 1'b0;
    cp_base = '0;
    cp_cnt  = '0;
    if (state == EMIT) begin
      cp_en   = present && mask_q[idx];
      cp_base = cur_off;
      cp_cnt  = cur_len;
    end else if (state == TAIL) begin
      cp_en   = 1'b1;
      cp_base = payload_start;
      cp_cnt  = (payload_start < MAX) ? (MAX - payload_start) : '0;
    end
  end

  assign cp_end = wr_ptr + cp_cnt;
  // any byte of a non-empty window past the buffer end is dropped
  assign cp_ovf = cp_en && (cp_cnt != '0) && (cp_end > MAX);

  // a payload start beyond wr_ptr+MAX wraps large and is clamped to MAX
  assign tail_len = wr_ptr + MAX - payload_start;
  assign len_nxt  = (tail_len > MAX) ? MAX : tail_len;

  for (genvar j = 0; j < HDR_MAX_LEN; j++) begin : g_lane
    deparser_byte #(.HDR_MAX_LEN(HDR_MAX_LEN), .POS(j)) u_byte (
      .src    (src_q),
      .wr_ptr (wr_ptr),
      .base   (cp_base),
      .cnt    (cp_cnt),
      .en     (cp_en),
      .hit    (lane_hit[j]),
      .data   (lane_data[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FREE;
      idx           <= '0;
      wr_ptr        <= '0;
      payload_start <= '0;
      src_q         <= '0;
      offs_q        <= '0;
      mask_q        <= '0;
      hdr_lens      <= '0;
      ready_o       <= 1'b0;
      overflow_o    <= 1'b0;
      pkt_len_o     <= '0;
      pkt_hdr_o     <= '0;
    end else begin
      case (state)
        FREE: begin
          if (mod_start_i) begin
            if (mod_hdr_id_i < NH) hdr_lens[mod_hdr_id_i[IW-1:0]] <= mod_hdr_len_i;
          end else if (start_i) begin
            src_q         <= pkt_hdr_i;
            offs_q        <= parsed_hdrs_i;
            mask_q        <= emit_mask_i;
            ready_o       <= 1'b0;
            overflow_o    <= 1'b0;
            pkt_hdr_o     <= '0;
            idx           <= '0;
            wr_ptr        <= '0;
            payload_start <= '0;
            state         <= EMIT;
          end
        end
        EMIT: begin
          for (int j = 0; j < HDR_MAX_LEN; j++)
            if (lane_hit[j]) pkt_hdr_o[j] <= lane_data[j];
          if (cp_ovf) overflow_o <= 1'b1;
          if (present && (hdr_end > payload_start)) payload_start <= hdr_end;
          if (cp_en) wr_ptr <= cp_end;
          if (idx == IW'(NUM_HEADERS - 1)) state <= TAIL;
          else                             idx   <= idx + 1'b1;
        end
        TAIL: begin
          for (int j = 0; j < HDR_MAX_LEN; j++)
            if (lane_hit[j]) pkt_hdr_o[j] <= lane_data[j];
          if (cp_ovf) overflow_o <= 1'b1;
          pkt_len_o <= len_nxt;
          ready_o   <= 1'b1;
          state     <= FREE;
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_deparser.sv
// Randomized + directed bench for deparser against a byte-loop reference model.
module tb_deparser;
  localparam int          NH   = 2;
  localparam int          HML  = 64;
  localparam logic [31:0] HMLU = 32'd64;
  localparam logic [31:0] NOH  = 32'hFFFF_FFFF;

  logic                   clk = 1'b0;
  logic                   rst, start_i, busy_o, ready_o, overflow_o, mod_start_i;
  logic [HML-1:0][7:0]    pkt_hdr_i, pkt_hdr_o;
  logic [NH-1:0][31:0]    parsed_hdrs_i;
  logic [NH-1:0]          emit_mask_i;
  logic [31:0]            pkt_len_o, mod_hdr_id_i, mod_hdr_len_i;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0]         lens_m [NH];
  logic [HML-1:0][7:0] exp_out;
  logic [31:0]         exp_len;
  logic                exp_ovf;

  deparser #(.NUM_HEADERS(NH), .HDR_MAX_LEN(HML), .NO_HEADER(NOH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .pkt_hdr_i     (pkt_hdr_i),
    .parsed_hdrs_i (parsed_hdrs_i),
    .emit_mask_i   (emit_mask_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .pkt_hdr_o     (pkt_hdr_o),
    .pkt_len_o     (pkt_len_o),
    .overflow_o    (overflow_o),
    .mod_start_i   (mod_start_i),
    .mod_hdr_id_i  (mod_hdr_id_i),
    .mod_hdr_len_i (mod_hdr_len_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk headers in id order, byte by byte, then append payload.
  task automatic model(input logic [HML-1:0][7:0] src, input logic [NH-1:0][31:0] offs,
                       input logic [NH-1:0] mask);
    logic [31:0] wr, ps, p, d, e;
    exp_out = '0;
    exp_ovf = 1'b0;
    wr = 0;
    ps = 0;
    for (int h = 0; h < NH; h++) begin
      if (offs[h] != NOH) begin
        e = offs[h] + lens_m[h];
        if (e > ps) ps = e;
        if (mask[h]) begin
          for (int k = 0; k < int'(lens_m[h]); k++) begin
            p = offs[h] + 32'(k);
            d = wr + 32'(k);
            if (d < HMLU) exp_out[d[5:0]] = (p < HMLU) ? src[p[5:0]] : 8'h00;
            else          exp_ovf = 1'b1;
          end
          wr = wr + lens_m[h];
        end
      end
    end
    for (int k = 0; ps + 32'(k) < HMLU; k++) begin
      p = ps + 32'(k);
      d = wr + 32'(k);
      if (d < HMLU) exp_out[d[5:0]] = src[p[5:0]];
      else          exp_ovf = 1'b1;
    end
    e = wr + HMLU - ps;
    exp_len = (e > HMLU) ? HMLU : e;
  endtask

  task automatic cfg(input logic [31:0] id, input logic [31:0] len);
    mod_start_i   = 1'b1;
    mod_hdr_id_i  = id;
    mod_hdr_len_i = len;
    @(posedge clk); #1;
    mod_start_i = 1'b0;
    if (id < 32'(NH)) lens_m[id[0]] = len;
  endtask

  task automatic run_job(input string tag, input logic [HML-1:0][7:0] src,
                         input logic [NH-1:0][31:0] offs, input logic [NH-1:0] mask);
    int cyc;
    model(src, offs, mask);
    pkt_hdr_i     = src;
    parsed_hdrs_i = offs;
    emit_mask_i   = mask;
    start_i       = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    // inputs must have been latched at start
    pkt_hdr_i     = {16{$urandom()}};
    parsed_hdrs_i = {$urandom(), $urandom()};
    emit_mask_i   = NH'($urandom());
    chk({tag, ".busy1"}, 512'(busy_o), 512'(1));
    chk({tag, ".rdy0"}, 512'(ready_o), 512'(0));
    cyc = 0;
    while (!ready_o && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, 512'(cyc), 512'(NH + 1));
    chk({tag, ".busy0"}, 512'(busy_o), 512'(0));
    chk({tag, ".out"}, pkt_hdr_o, exp_out);
    chk({tag, ".len"}, 512'(pkt_len_o), 512'(exp_len));
    chk({tag, ".ovf"}, 512'(overflow_o), 512'(exp_ovf));
  endtask

  logic [HML-1:0][7:0] inc, rsrc;
  logic [NH-1:0][31:0] offs;

  initial begin
    rst = 1'b1; start_i = 1'b0; mod_start_i = 1'b0;
    mod_hdr_id_i = '0; mod_hdr_len_i = '0;
    pkt_hdr_i = '0; parsed_hdrs_i = '0; emit_mask_i = '0;
    for (int h = 0; h < NH; h++) lens_m[h] = '0;
    for (int i = 0; i < HML; i++) inc[i] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 512'(ready_o), 512'(0));
    chk("rst.busy", 512'(busy_o), 512'(0));
    chk("rst.ovf", 512'(overflow_o), 512'(0));
    chk("rst.len", 512'(pkt_len_o), 512'(0));
    chk("rst.out", pkt_hdr_o, 512'(0));
    rst = 1'b0;

    cfg(0, 14);
    cfg(1, 20);
    offs[0] = 0; offs[1] = 14;
    run_job("pass",   inc, offs, 2'b11);
    run_job("strip1", inc, offs, 2'b01);
    run_job("strip0", inc, offs, 2'b10);
    offs[1] = NOH;
    run_job("absent", inc, offs, 2'b11);
    offs[0] = NOH;
    run_job("none",   inc, offs, 2'b11);

    // config strobe wins over start in the same cycle
    mod_start_i = 1'b1; mod_hdr_id_i = 1; mod_hdr_len_i = 8;
    start_i = 1'b1; pkt_hdr_i = inc;
    @(posedge clk); #1;
    mod_start_i = 1'b0; start_i = 1'b0;
    lens_m[1] = 8;
    chk("coll.busy", 512'(busy_o), 512'(0));
    chk("coll.rdy", 512'(ready_o), 512'(1));
    offs[0] = 0; offs[1] = 14;
    run_job("coll", inc, offs, 2'b01);

    cfg(7, 33);  // out-of-range id, ignored
    run_job("badid", inc, offs, 2'b11);

    cfg(0, 60);
    offs[0] = 10; offs[1] = NOH;
    run_job("far", inc, offs, 2'b11);

    cfg(0, 40); cfg(1, 40);
    offs[0] = 0; offs[1] = 0;
    run_job("ovf", inc, offs, 2'b11);

    // reset two edges into a job
    pkt_hdr_i = inc; parsed_hdrs_i = offs; emit_mask_i = 2'b11; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst.busy", 512'(busy_o), 512'(0));
    chk("mrst.rdy", 512'(ready_o), 512'(0));
    chk("mrst.len", 512'(pkt_len_o), 512'(0));
    chk("mrst.out", pkt_hdr_o, 512'(0));
    rst = 1'b0;
    for (int h = 0; h < NH; h++) lens_m[h] = '0;
    offs[0] = 3; offs[1] = 9;
    run_job("zlen", inc, offs, 2'b11);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) cfg(32'($urandom_range(0, 3)), 32'($urandom_range(0, 48)));
      for (int i = 0; i < HML; i++) rsrc[i] = 8'($urandom());
      for (int h = 0; h < NH; h++)
        offs[h] = ($urandom_range(0, 5) == 0) ? NOH : 32'($urandom_range(0, 80));
      run_job("rnd", rsrc, offs, NH'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
